// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES register-separated
// chunks, valid/ready on both sides with a single global stall.
module pipelined_rc_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_rc_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    localparam int unsigned ChunkW = WIDTH / STAGES;

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic                         ovf_q, ovf_d;
    logic                         en;

    // One enable for every stage: the pipe only moves when the output slot can drain.
    assign en         = ~v_q[STAGES-1] | out_ready_i;
    assign in_ready_o = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]  pa, pb, ps;
        logic              pc, pv;
        logic [ChunkW:0]   carry;
        logic [ChunkW-1:0] chunk_sum;

        if (k == 0) begin : g_head
            assign pa = a_i;
            assign pb = sub_i ? ~b_i : b_i;
            assign ps = '0;
            assign pc = sub_i | cin_i;
            assign pv = in_valid_i;
        end else begin : g_body
            assign pa = a_q[k-1];
            assign pb = b_q[k-1];
            assign ps = s_q[k-1];
            assign pc = c_q[k-1];
            assign pv = v_q[k-1];
        end

        assign carry[0] = pc;
        for (genvar i = 0; i < ChunkW; i++) begin : g_fa
            localparam int unsigned Bit = k * ChunkW + i;
            assign chunk_sum[i] = pa[Bit] ^ pb[Bit] ^ carry[i];
            assign carry[i+1]   = (pa[Bit] & pb[Bit]) | (carry[i] & (pa[Bit] ^ pb[Bit]));
        end

        for (genvar j = 0; j < WIDTH; j++) begin : g_sum
            if (j / ChunkW == k) begin : g_new
                assign s_d[k][j] = chunk_sum[j-k*ChunkW];
            end else begin : g_keep
                assign s_d[k][j] = ps[j];
            end
        end

        assign a_d[k] = pa;
        assign b_d[k] = pb;
        assign c_d[k] = carry[ChunkW];
        assign v_d[k] = pv;

        if (k == STAGES - 1) begin : g_ovf
            assign ovf_d = carry[ChunkW] ^ carry[ChunkW-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid_o = v_q[STAGES-1];
    assign sum_o       = s_q[STAGES-1];
    assign cout_o      = c_q[STAGES-1];
    assign ovf_o       = ovf_q;

    // Operands are fully consumed by the last stage.
    logic unused_ops;
    assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Scoreboard bench for pipelined_rc_adder: directed and random traffic on a 4-stage instance,
// plus random traffic with random backpressure on 1-, 2- and 16-stage instances.
module tb_pipelined_rc_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
        bit           lat;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain (W+1)-bit arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0]   r;
        logic [W-1:0] be;
        exp_t         e;
        be    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ov  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic         rst = 1'b1, in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b1, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;

    pipelined_rc_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf)
    );

    exp_t     q[$];
    int       pops = 0, run = 0, max_run = 0;
    bit       lat_chk = 1'b0;
    bit [2:0] sw_done = '0;

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
        exp_t e;
        bit   ok = 1'b0;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        e     = model(av, bv, cv, sv);
        e.lat = lat_chk;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                q.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
        check("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            run++;
            if (run > max_run) max_run = run;
            pops++;
            if (q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.s);
                check("cout", cout, e.co);
                check("ovf", ovf, e.ov);
                // Result is visible STAGES cycles after the cycle in which it was accepted.
                if (e.lat) check("latency", cyc - e.acc, S);
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", cout, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        @(posedge clk); #1;

        // Directed corner cases with exact latency.
        lat_chk = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        drain();

        // Back-to-back random burst.
        max_run = 0;
        for (int n = 0; n < 32; n++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        drain();
        check("b2b_run", 32'(max_run >= 32), 32'd1);

        // Fill the pipe, stall for 5 cycles with a fifth beat waiting at the input.
        lat_chk   = 1'b0;
        p0        = pops;
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        fork
            send(16'h1234, 16'h4321, 1'b1, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 32'd0);
                    check("stall_out_valid", out_valid, 32'd1);
                    check("stall_sum", sum, q[0].s);
                    check("stall_cout", cout, q[0].co);
                    check("stall_ovf", ovf, q[0].ov);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_pops", pops - p0, 32'd5);

        // Reset with three beats in flight: all of them vanish.
        for (int n = 0; n < 3; n++)
            send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 32'd0);
        check("flush_in_ready", in_ready, 32'd1);
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        lat_chk = 1'b1;
        send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        drain();

        for (int t = 0; t < 5000 && sw_done != 3'b111; t++) @(posedge clk);
        check("sweep_done", 32'(sw_done), 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SS = (g == 0) ? 1 : ((g == 1) ? 2 : 16);

        logic         s_rst = 1'b1, s_iv = 1'b0, s_ir, s_sub = 1'b0;
        logic         s_ov, s_or = 1'b0, s_co, s_ovf;
        logic [W-1:0] s_a = '0, s_b = '0, s_sum;
        exp_t         sq[$];

        pipelined_rc_adder #(.WIDTH(W), .STAGES(SS)) u_dut (
            .clk_i       (clk),
            .rst_i       (s_rst),
            .in_valid_i  (s_iv),
            .in_ready_o  (s_ir),
            .a_i         (s_a),
            .b_i         (s_b),
            .cin_i       (1'b1),
            .sub_i       (s_sub),
            .out_valid_o (s_ov),
            .out_ready_i (s_or),
            .sum_o       (s_sum),
            .cout_o      (s_co),
            .ovf_o       (s_ovf)
        );

        always @(posedge clk) begin
            #1;
            s_or = ($urandom_range(0, 3) != 0);
        end

        initial begin
            exp_t e;
            bit   ok;
            repeat (2) @(posedge clk);
            #1 s_rst = 1'b0;
            for (int n = 0; n < 60; n++) begin
                s_a   = W'($urandom);
                s_b   = W'($urandom);
                s_sub = ($urandom_range(0, 3) == 0);
                s_iv  = 1'b1;
                e     = model(s_a, s_b, 1'b1, s_sub);
                ok    = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (s_ir) begin
                        sq.push_back(e);
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) check("sweep_accept", 32'd0, 32'd1);
                @(posedge clk); #1;
                s_iv = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                end
            end
            for (int t = 0; t < 300 && sq.size() != 0; t++) @(posedge clk);
            check("sweep_drain", sq.size(), 32'd0);
            sw_done[g] = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (!s_rst && s_ov && s_or) begin
                if (sq.size() == 0) begin
                    check("sweep_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sq.pop_front();
                    check("sweep_sum", s_sum, e.s);
                    check("sweep_cout", s_co, e.co);
                    check("sweep_ovf", s_ovf, e.ov);
                end
            end
        end
    end

endmodule
